// File: rtl/dma_copy_pkg.sv
// rtl/dma_copy_pkg.sv - shared constants and FSM encoding for the dma_copy engine
package dma_copy_pkg;

  localparam logic [5:0] MMIO_SUBPREFIX = 6'h05;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_SRC    = 8'h10;
  localparam logic [7:0] ADDR_DST    = 8'h11;
  localparam logic [7:0] ADDR_LEN    = 8'h12;
  localparam logic [7:0] ADDR_REMAIN = 8'h13;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_ERROR   = 2;
  localparam int STATUS_ABORTED = 3;

  localparam logic [3:0] WSTRB_WORD = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/dma_copy_master.sv
// rtl/dma_copy_master.sv - copy FSM and native valid/ready bus initiator
// Optional request timeout enabled by DMA_COPY_TIMEOUT_EN.
module dma_copy_master
  import dma_copy_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src,
  input  logic [31:0]          dst,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 aborted,
  output logic [LEN_WIDTH-1:0] remain,
  output logic                 mem_valid,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready
);

`ifdef DMA_COPY_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t           state;
  logic [31:0]      cur_src;
  logic [31:0]      cur_dst;
  logic [31:0]      data;
  logic             abort_pend;
  logic             stop_req;
  logic             timed_out;
  logic [CNT_W-1:0] wait_cnt;

  assign busy     = (state != ST_IDLE);
  assign stop_req = abort_pend | abort;

  // Counter folds to constant zero when the timeout feature is compiled out.
  always_ff @(posedge clk) begin
    if (reset || !TIMEOUT_EN || !mem_valid || mem_ready) wait_cnt <= '0;
    else                                                  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = TIMEOUT_EN && mem_valid && !mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      data       <= '0;
      remain     <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      aborted    <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            if (len != '0) begin
              cur_src <= src;
              cur_dst <= dst;
              remain  <= len;
              done    <= 1'b0;
              error   <= 1'b0;
              aborted <= 1'b0;
              state   <= ST_READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (abort) abort_pend <= 1'b1;
          if (!mem_valid) begin
            // Gap cycle between beats: nothing is in flight, so abort lands here.
            if (stop_req) begin
              aborted <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              mem_valid <= 1'b1;
              if (state == ST_READ) begin
                mem_addr  <= cur_src;
                mem_wstrb <= 4'h0;
              end else begin
                mem_addr  <= cur_dst;
                mem_wdata <= data;
                mem_wstrb <= WSTRB_WORD;
              end
            end
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            if (state == ST_READ) begin
              data <= mem_rdata;
              if (stop_req) begin
                aborted <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                state <= ST_WRITE;
              end
            end else begin
              remain  <= remain - 1'b1;
              cur_src <= cur_src + 32'd4;
              cur_dst <= cur_dst + 32'd4;
              if (remain == LEN_WIDTH'(1)) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else if (stop_req) begin
                aborted <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                state <= ST_READ;
              end
            end
          end else if (timed_out) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            error     <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - memory-to-memory word copy engine: MMIO register file and slave port
// Optional request timeout enabled by DMA_COPY_TIMEOUT_EN.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        irq
);

  logic [31:0]          src_reg;
  logic [31:0]          dst_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic                 irq_en;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 aborted;
  logic [LEN_WIDTH-1:0] remain;
  logic                 ctrl_wr;
  logic                 start_req;
  logic                 abort_req;

  assign ctrl_wr   = cs && we && (address == ADDR_CTRL);
  // Abort takes priority over start in the same CTRL write.
  assign abort_req = ctrl_wr && write_data[CTRL_ABORT];
  assign start_req = ctrl_wr && write_data[CTRL_START] && !write_data[CTRL_ABORT];

  always_ff @(posedge clk) begin
    if (reset) begin
      ready   <= 1'b0;
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
      irq_en  <= 1'b0;
    end else begin
      ready <= cs;
      if (cs && we) begin
        case (address)
          ADDR_CTRL: irq_en <= write_data[CTRL_IRQ_EN];
          ADDR_SRC:  if (!busy) src_reg <= {write_data[31:2], 2'b00};
          ADDR_DST:  if (!busy) dst_reg <= {write_data[31:2], 2'b00};
          ADDR_LEN:  if (!busy) len_reg <= write_data[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (cs) begin
      case (address)
        ADDR_CTRL: read_data[CTRL_IRQ_EN] = irq_en;
        ADDR_STATUS: begin
          read_data[STATUS_BUSY]    = busy;
          read_data[STATUS_DONE]    = done;
          read_data[STATUS_ERROR]   = error;
          read_data[STATUS_ABORTED] = aborted;
        end
        ADDR_SRC:    read_data = src_reg;
        ADDR_DST:    read_data = dst_reg;
        ADDR_LEN:    read_data = 32'(len_reg);
        ADDR_REMAIN: read_data = 32'(remain);
        default:     read_data = '0;
      endcase
    end
  end

  assign irq = done && irq_en;

  dma_copy_master #(
    .LEN_WIDTH      (LEN_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_master (
    .clk       (clk),
    .reset     (reset),
    .start     (start_req),
    .abort     (abort_req),
    .src       (src_reg),
    .dst       (dst_reg),
    .len       (len_reg),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .aborted   (aborted),
    .remain    (remain),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - self-checking bench for dma_copy with a memory responder and transfer model
module tb_dma_copy;
  import dma_copy_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  dma_copy #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [bit [31:0]];
  int          lat = 0;
  bit          resp_en = 1'b1;
  bit          pending = 1'b0;
  int          wcnt = 0;
  logic [67:0] hold;
  int          drop_cnt = 0;
  int          unstable_cnt = 0;
  int          valid_cycles = 0;
  logic [3:0]  hs_strb [$];
  logic [31:0] hs_addr [$];
  logic [31:0] hs_data [$];
  logic [3:0]  exp_strb [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic        ctrl_irq = 1'b0;

  // Memory responder: ready after 'lat' waiting cycles, one-cycle pulse.
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      pending   = 1'b0;
    end else begin
      if (mem_valid) valid_cycles++;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid && resp_en) begin
        if (!pending) begin
          pending = 1'b1;
          wcnt    = 0;
          hold    = {mem_addr, mem_wdata, mem_wstrb};
        end else if ({mem_addr, mem_wdata, mem_wstrb} !== hold) begin
          unstable_cnt++;
        end
        if (wcnt >= lat) begin
          pending = 1'b0;
          hs_strb.push_back(mem_wstrb);
          hs_addr.push_back(mem_addr);
          if (mem_wstrb == 4'hf) begin
            mem[mem_addr] = mem_wdata;
            hs_data.push_back(mem_wdata);
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
            hs_data.push_back(mem_rdata);
          end
          mem_ready = 1'b1;
        end else begin
          wcnt++;
        end
      end else if (pending && !mem_valid) begin
        drop_cnt++;
        pending = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    mmio_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 2000 && st[0]; i++) mmio_read(ADDR_STATUS, st);
    check({tag, "_idle"}, {31'b0, st[0]}, 32'h0);
  endtask

  // Reference: each word is a read of src+4i followed by a write of the same value to dst+4i.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int l, input bit fill);
    logic [31:0] a;
    hs_strb.delete(); hs_addr.delete(); hs_data.delete();
    exp_strb.delete(); exp_addr.delete(); exp_data.delete();
    lat = l;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      if (fill) mem[a] = $urandom;
      exp_strb.push_back(4'h0); exp_addr.push_back(a); exp_data.push_back(mem[a]);
      exp_strb.push_back(4'hf); exp_addr.push_back(dst + 32'(4 * i)); exp_data.push_back(mem[a]);
    end
    mmio_write(ADDR_SRC, src);
    mmio_write(ADDR_DST, dst);
    mmio_write(ADDR_LEN, 32'(len));
    mmio_write(ADDR_CTRL, {29'b0, ctrl_irq, 2'b01});
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_beats"}, 32'(hs_strb.size()), 32'(exp_strb.size()));
    n = (hs_strb.size() < exp_strb.size()) ? hs_strb.size() : exp_strb.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_strb%0d", tag, i), {28'b0, hs_strb[i]}, {28'b0, exp_strb[i]});
      check($sformatf("%s_addr%0d", tag, i), hs_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), hs_data[i], exp_data[i]);
    end
    check({tag, "_nodrop"}, 32'(drop_cnt), 32'h0);
    check({tag, "_stable"}, 32'(unstable_cnt), 32'h0);
  endtask

  task automatic finish_copy(input string tag, input logic [31:0] dst, input int len);
    wait_idle(tag);
    compare_log(tag);
    for (int i = 0; i < len; i++)
      check($sformatf("%s_dst%0d", tag, i), mem[dst + 32'(4 * i)], exp_data[2 * i]);
    reg_check({tag, "_status"}, ADDR_STATUS, 32'h2);
    reg_check({tag, "_remain"}, ADDR_REMAIN, 32'h0);
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, ctrl_irq});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] s;
    logic [31:0] d;
    logic [7:0]  regs [6];
    regs = '{ADDR_CTRL, ADDR_STATUS, ADDR_SRC, ADDR_DST, ADDR_LEN, ADDR_REMAIN};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 6; i++) reg_check($sformatf("rst_reg_%0h", regs[i]), regs[i], 32'h0);
    #1 check("ready_latency", {31'b0, ready}, 32'h1);
    @(negedge clk); #1 check("ready_drop", {31'b0, ready}, 32'h0);
    reg_check("unmapped", 8'h3f, 32'h0);

    // Basic three-word copy with irq enabled
    ctrl_irq = 1'b1;
    mem[32'h4000_0000] = 32'h11;
    mem[32'h4000_0004] = 32'h22;
    mem[32'h4000_0008] = 32'h33;
    start_copy(32'h4000_0000, 32'h4000_0100, 3, 1, 1'b0);
    finish_copy("basic", 32'h4000_0100, 3);
    ctrl_irq = 1'b0;
    mmio_write(ADDR_CTRL, 32'h0);
    #1 check("irq_masked", {31'b0, irq}, 32'h0);

    // Low address bits forced to zero
    mmio_write(ADDR_SRC, 32'h1234_5677);
    reg_check("src_align", ADDR_SRC, 32'h1234_5674);
    d = $urandom | 32'h3;
    mmio_write(ADDR_DST, d);
    reg_check("dst_align", ADDR_DST, d & ~32'h3);

    // Abort during an in-flight read beat
    start_copy(32'h4000_1000, 32'h4000_2000, 8, 3, 1'b1);
    for (int i = 0; i < 500 && hs_strb.size() < 4; i++) begin @(negedge clk); #2; end
    check("abort_sync", 32'(hs_strb.size()), 32'h4);
    @(negedge clk);
    mmio_write(ADDR_CTRL, 32'h3);
    wait_idle("abort");
    while (exp_strb.size() > 5) begin
      void'(exp_strb.pop_back()); void'(exp_addr.pop_back()); void'(exp_data.pop_back());
    end
    compare_log("abort");
    reg_check("abort_status", ADDR_STATUS, 32'h8);
    reg_check("abort_remain", ADDR_REMAIN, 32'h6);

    // Zero-length start: done only, no bus traffic
    mmio_write(ADDR_LEN, 32'h0);
    valid_cycles = 0;
    mmio_write(ADDR_CTRL, 32'h1);
    mmio_read(ADDR_STATUS, v);
    check("zero_status", v & 32'h3, 32'h2);
    repeat (20) @(negedge clk);
    check("zero_no_valid", 32'(valid_cycles), 32'h0);

    // Address wrap at the top of the 32-bit space
    start_copy(32'hFFFF_FFF8, 32'h5000_0000, 3, 1, 1'b1);
    finish_copy("wrap", 32'h5000_0000, 3);
    check("wrap_a0", hs_addr[0], 32'hFFFF_FFF8);
    check("wrap_a1", hs_addr[2], 32'hFFFF_FFFC);
    check("wrap_a2", hs_addr[4], 32'h0000_0000);

    // Register writes and start while busy are ignored
    start_copy(32'h4000_3000, 32'h4000_4000, 4, 2, 1'b1);
    mmio_read(ADDR_STATUS, v);
    check("busy_seen", v & 32'h1, 32'h1);
    mmio_write(ADDR_SRC, 32'h7000_0000);
    mmio_write(ADDR_LEN, 32'h1);
    mmio_write(ADDR_CTRL, 32'h1);
    finish_copy("busywr", 32'h4000_4000, 4);
    reg_check("busywr_src", ADDR_SRC, 32'h4000_3000);
    reg_check("busywr_len", ADDR_LEN, 32'h4);

    // Randomized copies
    for (int t = 0; t < 4; t++) begin
      int n;
      s = 32'h1000_0000 + 32'($urandom_range(0, 1023)) * 4;
      d = 32'h2000_0000 + 32'($urandom_range(0, 1023)) * 4;
      n = $urandom_range(1, 6);
      ctrl_irq = t[0];
      start_copy(s, d, n, $urandom_range(0, 3), 1'b1);
      finish_copy($sformatf("rand%0d", t), d, n);
    end

`ifdef DMA_COPY_TIMEOUT_EN
    // Responder never answers: request times out
    ctrl_irq = 1'b1;
    resp_en  = 1'b0;
    mmio_write(ADDR_SRC, 32'h4000_5000);
    mmio_write(ADDR_LEN, 32'h2);
    valid_cycles = 0;
    mmio_write(ADDR_CTRL, 32'h5);
    wait_idle("tmo");
    check("tmo_valid_cycles", 32'(valid_cycles), 32'(TMO));
    reg_check("tmo_status", ADDR_STATUS, 32'h4);
    reg_check("tmo_remain", ADDR_REMAIN, 32'h2);
    check("tmo_irq", {31'b0, irq}, 32'h0);
    resp_en = 1'b1;
`endif

    // Reset asserted while a read request is outstanding
    ctrl_irq = 1'b1;
    start_copy(32'h4000_6000, 32'h4000_7000, 4, 5, 1'b1);
    for (int i = 0; i < 100 && !mem_valid; i++) begin @(negedge clk); #2; end
    check("rstmid_valid_seen", {31'b0, mem_valid}, 32'h1);
    check("rstmid_in_read", {28'b0, mem_wstrb}, 32'h0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rstmid_valid", {31'b0, mem_valid}, 32'h0);
    check("rstmid_addr", mem_addr, 32'h0);
    check("rstmid_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    ctrl_irq = 1'b0;
    for (int i = 0; i < 6; i++) reg_check($sformatf("rstmid_reg_%0h", regs[i]), regs[i], 32'h0);
    repeat (10) @(negedge clk);
    check("rstmid_quiet", {31'b0, mem_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
